// File: rtl/utf8_decode_sequencer.sv
// utf8_decode_sequencer
// Streaming UTF-8 decoder. Accepts one byte per cycle and emits one Unicode
// scalar (or an error marker) through a single-entry output register.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_byte      byte stream input
//   in_ready              byte consumed when in_valid && in_ready
//   flush                 drop any partially received sequence
//   out_valid/out_cp      decoded code point (or ERR_CP on error)
//   out_err               the current output is an error
//   out_ready             output consumed when out_valid && out_ready
//   busy                  a partial multi-byte sequence is held
//   err_count             saturating count of errors emitted
module utf8_decode_sequencer #(
   parameter bit          ALLOW_SURROGATE = 1'b0,
   parameter logic [20:0] ERR_CP          = 21'h00FFFD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_byte,
   output logic        in_ready,
   input  logic        flush,
   output logic        out_valid,
   output logic [20:0] out_cp,
   output logic        out_err,
   input  logic        out_ready,
   output logic        busy,
   output logic [7:0]  err_count
);

   typedef enum logic {IDLE, CONT} state_t;

   state_t      state;
   logic [1:0]  rem;
   logic [2:0]  len;
   logic [20:0] acc;

   logic        out_free;
   logic        is_cont;
   logic        is_lead;
   logic        take;
   logic        trunc;
   logic [20:0] acc_next;
   logic        final_bad;
   logic        emit;
   logic        emit_err;
   logic [20:0] emit_cp;

   // Output register can take a new value this cycle if empty or draining.
   assign out_free = !out_valid || out_ready;
   assign is_cont  = (in_byte[7:6] == 2'b10);
   assign is_lead  = (in_byte >= 8'hC2) && (in_byte <= 8'hF4);

   // In CONT a non-continuation byte is never consumed: it ends the
   // sequence with an error and is re-examined from IDLE.
   assign in_ready = !rst && !flush && out_free && ((state == IDLE) || is_cont);
   assign take     = in_valid && in_ready;
   assign trunc    = !rst && !flush && out_free && (state == CONT) && in_valid && !is_cont;

   assign acc_next = (acc << 6) | {15'd0, in_byte[5:0]};

   always_comb begin
      final_bad = 1'b0;
      if ((len == 3'd3) && (acc_next < 21'h000800))
         final_bad = 1'b1;
      if ((len == 3'd4) && (acc_next < 21'h010000))
         final_bad = 1'b1;
      if (!ALLOW_SURROGATE && (acc_next >= 21'h00D800) && (acc_next <= 21'h00DFFF))
         final_bad = 1'b1;
      if (acc_next > 21'h10FFFF)
         final_bad = 1'b1;
   end

   // What (if anything) gets loaded into the output register this cycle.
   always_comb begin
      emit     = 1'b0;
      emit_err = 1'b0;
      emit_cp  = ERR_CP;
      if (take && (state == IDLE)) begin
         if (!in_byte[7]) begin
            emit    = 1'b1;
            emit_cp = {13'd0, in_byte};
         end else if (!is_lead) begin
            emit     = 1'b1;
            emit_err = 1'b1;
         end
      end else if (take && (state == CONT) && (rem == 2'd1)) begin
         emit = 1'b1;
         if (final_bad)
            emit_err = 1'b1;
         else
            emit_cp = acc_next;
      end else if (trunc) begin
         emit     = 1'b1;
         emit_err = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         rem       <= 2'd0;
         len       <= 3'd0;
         acc       <= 21'd0;
         out_valid <= 1'b0;
         out_cp    <= 21'd0;
         out_err   <= 1'b0;
         err_count <= 8'd0;
      end else begin
         if (out_ready)
            out_valid <= 1'b0;

         // emit is only ever raised when out_free, so nothing is overwritten
         if (emit) begin
            out_valid <= 1'b1;
            out_cp    <= emit_cp;
            out_err   <= emit_err;
            if (emit_err && (err_count != 8'hFF))
               err_count <= err_count + 8'd1;
         end

         if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            rem   <= 2'd0;
            len   <= 3'd0;
            acc   <= 21'd0;
         end else if (take && (state == IDLE) && is_lead) begin
            state <= CONT;
            busy  <= 1'b1;
            if (in_byte <= 8'hDF) begin
               acc <= {16'd0, in_byte[4:0]};
               rem <= 2'd1;
               len <= 3'd2;
            end else if (in_byte <= 8'hEF) begin
               acc <= {17'd0, in_byte[3:0]};
               rem <= 2'd2;
               len <= 3'd3;
            end else begin
               acc <= {18'd0, in_byte[2:0]};
               rem <= 2'd3;
               len <= 3'd4;
            end
         end else if (take && (state == CONT)) begin
            acc <= acc_next;
            rem <= rem - 2'd1;
            if (rem == 2'd1) begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         end else if (trunc) begin
            state <= IDLE;
            busy  <= 1'b0;
            rem   <= 2'd0;
            len   <= 3'd0;
            acc   <= 21'd0;
         end
      end
   end

endmodule
